data_memory_ctrl: RTL

Parametrised, clocked data memory for the pipelined CPU's MEM stage. It replaces the combinational word-only array with a registered-response memory that supports byte, halfword and word accesses, optional sign extension and a configurable response latency. A req/ready/ack handshake lets the pipeline stall on it, and misaligned or out-of-range accesses are reported as errors.

---
 rtl/data_memory_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Registered-response data memory for the MEM stage: byte/half/word access,
// sign/zero extension, configurable latency and a req/ready/ack handshake.
module data_memory_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [31:0]       data_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        data_q, data_d;

  // Captured request, held until its response is issued.
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         lane_q, lane_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               perr_q, perr_d;

  logic [31:0]        mem_q [DEPTH];

  logic               accept_c;
  logic               req_err_c;
  logic               wr_en_c;
  logic [3:0]         wr_be_c;
  logic [31:0]        wr_data_c;
  logic [31:0]        rd_shift_c;
  logic [31:0]        load_c;

  assign accept_c  = req_i && ready_q && rst_i;
  assign req_err_c = (size_i == 2'd3)
                  || ((size_i == 2'd1) && addr_i[0])
                  || ((size_i == 2'd2) && (addr_i[1:0] != 2'd0))
                  || ((addr_i >> 2) >= ADDR_W'(DEPTH));

  // Request capture; the _d values double as the read/write selection.
  always_comb begin
    we_d   = we_q;
    size_d = size_q;
    uns_d  = uns_q;
    lane_d = lane_q;
    idx_d  = idx_q;
    perr_d = perr_q;
    if (accept_c) begin
      we_d   = we_i;
      size_d = size_i;
      uns_d  = unsigned_i;
      lane_d = addr_i[1:0];
      idx_d  = addr_i[IDX_W+1:2];
      perr_d = req_err_c;
    end
  end

  // Store lane enables and lane-replicated write data.
  always_comb begin
    wr_en_c   = accept_c && we_i && !req_err_c;
    wr_be_c   = 4'b1111;
    wr_data_c = data_i;
    case (size_i)
      2'd0: begin
        wr_be_c   = 4'b0001 << addr_i[1:0];
        wr_data_c = {4{data_i[7:0]}};
      end
      2'd1: begin
        wr_be_c   = addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data_c = {2{data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be_c[l]) mem_q[idx_d][8*l +: 8] <= wr_data_c[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      lane_q  <= '0;
      idx_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else if (state_q == ST_RESP) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Array is read on the edge entering RESP; outputs follow the next state.
  always_comb begin
    rd_shift_c = mem_q[idx_d] >> {lane_d, 3'b000};
    case (size_d)
      2'd0:    load_c = {{24{~uns_d & rd_shift_c[7]}},  rd_shift_c[7:0]};
      2'd1:    load_c = {{16{~uns_d & rd_shift_c[15]}}, rd_shift_c[15:0]};
      default: load_c = rd_shift_c;
    endcase
    ready_d = (state_d != ST_WAIT);
    ack_d   = (state_d == ST_RESP);
    err_d   = ack_d && perr_d;
    data_d  = (ack_d && !perr_d && !we_d) ? load_c : 32'd0;
  end

  assign ready_o = ready_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule
